// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for a 3-requester register-file write port, with a busy
// scoreboard for issued destinations and hazard/bypass detection on two read ports.
module regfile_wb_arbiter #(
   parameter bit RR_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic [4:0]  req0_addr,
   input  logic [31:0] req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [4:0]  req1_addr,
   input  logic [31:0] req1_data,
   output logic        req1_ready,
   input  logic        req2_valid,
   input  logic [4:0]  req2_addr,
   input  logic [31:0] req2_data,
   output logic        req2_ready,
   input  logic        iss_valid,
   input  logic [4:0]  iss_addr,
   output logic        iss_ready,
   input  logic [4:0]  raddr1,
   input  logic [4:0]  raddr2,
   output logic        hz1,
   output logic        hz2,
   output logic        byp1_hit,
   output logic        byp2_hit,
   output logic [31:0] byp_data,
   output logic        wen,
   output logic [4:0]  waddr,
   output logic [31:0] wdata
);

   logic [2:0]  reqValid;
   logic [4:0]  reqAddr [3];
   logic [31:0] reqData [3];

   logic [2:0]  grantOh;
   logic [1:0]  grantIdx;
   logic        grantAny;

   logic [1:0]  rrPtr_q, rrPtr_d;
   logic        wen_q, wen_d;
   logic [4:0]  waddr_q, waddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] busy_q, busy_d;

   assign reqValid   = {req2_valid, req1_valid, req0_valid};
   assign reqAddr[0] = req0_addr;
   assign reqAddr[1] = req1_addr;
   assign reqAddr[2] = req2_addr;
   assign reqData[0] = req0_data;
   assign reqData[1] = req1_data;
   assign reqData[2] = req2_data;

   function automatic logic [1:0] wrapIdx(input logic [1:0] base, input logic [1:0] step);
      logic [2:0] s;
      s = {1'b0, base} + {1'b0, step};
      if (s >= 3'd3) s = s - 3'd3;
      return s[1:0];
   endfunction

   // Round-robin starts one past the last winner; fixed priority always starts at req0.
   always_comb begin
      logic [1:0] cand;
      grantOh  = 3'b000;
      grantIdx = 2'd0;
      grantAny = 1'b0;
      cand     = 2'd0;
      for (int k = 0; k < 3; k++) begin
         if (RR_EN) cand = wrapIdx(rrPtr_q, 2'(k + 1));
         else       cand = 2'(k);
         if (!grantAny && reqValid[cand]) begin
            grantAny       = 1'b1;
            grantIdx       = cand;
            grantOh[cand]  = 1'b1;
         end
      end
   end

   assign req0_ready = grantOh[0];
   assign req1_ready = grantOh[1];
   assign req2_ready = grantOh[2];

   assign iss_ready = !busy_q[iss_addr] || (iss_addr == 5'd0);

   // Writes to r0 are accepted but never reach the register file.
   always_comb begin
      rrPtr_d = rrPtr_q;
      wen_d   = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (grantAny) begin
         rrPtr_d = grantIdx;
         wen_d   = (reqAddr[grantIdx] != 5'd0);
         waddr_d = reqAddr[grantIdx];
         wdata_d = reqData[grantIdx];
      end
   end

   always_comb begin
      busy_d = busy_q;
      if (wen_q) busy_d[waddr_q] = 1'b0;
      if (iss_valid && iss_ready) busy_d[iss_addr] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rrPtr_q <= 2'd2;
         wen_q   <= 1'b0;
         waddr_q <= 5'd0;
         wdata_q <= 32'd0;
         busy_q  <= 32'd0;
      end else begin
         rrPtr_q <= rrPtr_d;
         wen_q   <= wen_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
      end
   end

   assign wen      = wen_q;
   assign waddr    = waddr_q;
   assign wdata    = wdata_q;
   assign byp_data = wdata_q;

   assign byp1_hit = wen_q && (waddr_q == raddr1) && (raddr1 != 5'd0);
   assign byp2_hit = wen_q && (waddr_q == raddr2) && (raddr2 != 5'd0);
   assign hz1      = busy_q[raddr1] && !byp1_hit;
   assign hz2      = busy_q[raddr2] && !byp2_hit;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected grants and writes are queued
// by the stimulus and consumed by a negedge monitor; combinational flags are checked inline.
module tb_regfile_wb_arbiter;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid, req2_valid;
   logic [4:0]  req0_addr, req1_addr, req2_addr;
   logic [31:0] req0_data, req1_data, req2_data;
   logic        req0_ready, req1_ready, req2_ready;
   logic        iss_valid;
   logic [4:0]  iss_addr;
   logic        iss_ready;
   logic [4:0]  raddr1, raddr2;
   logic        hz1, hz2, byp1_hit, byp2_hit;
   logic [31:0] byp_data;
   logic        wen;
   logic [4:0]  waddr;
   logic [31:0] wdata;

   logic        fpReady0, fpReady1, fpReady2, fpIssReady;
   logic        fpHz1, fpHz2, fpByp1, fpByp2, fpWen;
   logic [31:0] fpBypData, fpWdata;
   logic [4:0]  fpWaddr;

   int  errors = 0;
   int  checks = 0;
   int  expGrant[$];
   wr_t expWr[$];

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.RR_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
      .req2_valid(req2_valid), .req2_addr(req2_addr), .req2_data(req2_data), .req2_ready(req2_ready),
      .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
      .raddr1(raddr1), .raddr2(raddr2), .hz1(hz1), .hz2(hz2),
      .byp1_hit(byp1_hit), .byp2_hit(byp2_hit), .byp_data(byp_data),
      .wen(wen), .waddr(waddr), .wdata(wdata)
   );

   regfile_wb_arbiter #(.RR_EN(1'b0)) dutFp (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(fpReady0),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(fpReady1),
      .req2_valid(req2_valid), .req2_addr(req2_addr), .req2_data(req2_data), .req2_ready(fpReady2),
      .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(fpIssReady),
      .raddr1(raddr1), .raddr2(raddr2), .hz1(fpHz1), .hz2(fpHz2),
      .byp1_hit(fpByp1), .byp2_hit(fpByp2), .byp_data(fpBypData),
      .wen(fpWen), .waddr(fpWaddr), .wdata(fpWdata)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input int idx, input logic v, input logic [4:0] a, input logic [31:0] d);
      case (idx)
         0: begin req0_valid = v; req0_addr = a; req0_data = d; end
         1: begin req1_valid = v; req1_addr = a; req1_data = d; end
         default: begin req2_valid = v; req2_addr = a; req2_data = d; end
      endcase
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Grants and committed writes are consumed in order, mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if ({req2_ready, req1_ready, req0_ready} != 3'b000) begin
            checks++;
            if (expGrant.size() == 0) begin
               errors++;
               $display("[TB] FAIL grant: got ready=%b, expected no grant", {req2_ready, req1_ready, req0_ready});
            end else begin
               int g;
               g = expGrant.pop_front();
               if ({req2_ready, req1_ready, req0_ready} != (3'b001 << g)) begin
                  errors++;
                  $display("[TB] FAIL grant: got ready=%b, expected requester %0d", {req2_ready, req1_ready, req0_ready}, g);
               end
            end
         end
         if (wen) begin
            checks++;
            if (expWr.size() == 0) begin
               errors++;
               $display("[TB] FAIL write: got wen=1 waddr=%0d wdata=0x%08h, expected no write", waddr, wdata);
            end else begin
               wr_t w;
               w = expWr.pop_front();
               if (waddr !== w.a || wdata !== w.d) begin
                  errors++;
                  $display("[TB] FAIL write: got waddr=%0d wdata=0x%08h, expected waddr=%0d wdata=0x%08h",
                           waddr, wdata, w.a, w.d);
               end
            end
         end
      end
   end

   initial begin
      int rrExp[5];
      rrExp = '{0, 1, 2, 0, 1};
      rst_n = 1'b0;
      applyStimulus(0, 1'b0, 5'd0, 32'd0);
      applyStimulus(1, 1'b0, 5'd0, 32'd0);
      applyStimulus(2, 1'b0, 5'd0, 32'd0);
      iss_valid = 1'b0; iss_addr = 5'd7; raddr1 = 5'd7; raddr2 = 5'd9;
      #2;
      checkOutput("reset_wen", 32'(wen), 32'd0);
      checkOutput("reset_waddr", 32'(waddr), 32'd0);
      checkOutput("reset_wdata", wdata, 32'd0);
      checkOutput("reset_hz1", 32'(hz1), 32'd0);
      checkOutput("reset_hz2", 32'(hz2), 32'd0);
      checkOutput("reset_iss_ready", 32'(iss_ready), 32'd1);
      nextCycle();
      nextCycle();
      rst_n = 1'b1;

      // All three requesters contend for five cycles.
      for (int i = 0; i < 5; i++) begin
         if (i > 0) nextCycle();
         applyStimulus(0, 1'b1, 5'd1, 32'hA000_0000);
         applyStimulus(1, 1'b1, 5'd2, 32'hB000_0001);
         applyStimulus(2, 1'b1, 5'd3, 32'hC000_0002);
         expGrant.push_back(rrExp[i]);
         case (rrExp[i])
            0: expWr.push_back('{5'd1, 32'hA000_0000});
            1: expWr.push_back('{5'd2, 32'hB000_0001});
            default: expWr.push_back('{5'd3, 32'hC000_0002});
         endcase
         #1;
         checkOutput("fp_ready", {29'd0, fpReady2, fpReady1, fpReady0}, 32'b001);
      end
      nextCycle();
      applyStimulus(0, 1'b0, 5'd0, 32'd0);
      applyStimulus(1, 1'b0, 5'd0, 32'd0);
      applyStimulus(2, 1'b0, 5'd0, 32'd0);

      // Single request from req0.
      nextCycle();
      applyStimulus(0, 1'b1, 5'd5, 32'h0000_1234);
      expGrant.push_back(0);
      expWr.push_back('{5'd5, 32'h0000_1234});
      #1;
      checkOutput("single_ready", 32'(req0_ready), 32'd1);
      nextCycle();
      applyStimulus(0, 1'b0, 5'd0, 32'd0);
      #1;
      checkOutput("single_wen", 32'(wen), 32'd1);
      checkOutput("single_waddr", 32'(waddr), 32'd5);

      // Reserve r7, then write it back through req1.
      nextCycle();
      iss_valid = 1'b1; iss_addr = 5'd7; raddr1 = 5'd0; raddr2 = 5'd0;
      #1;
      checkOutput("iss7_ready", 32'(iss_ready), 32'd1);
      nextCycle();
      raddr1 = 5'd7;
      #1;
      checkOutput("busy7_hz1", 32'(hz1), 32'd1);
      checkOutput("reiss7_ready", 32'(iss_ready), 32'd0);
      nextCycle();
      iss_valid = 1'b0;
      applyStimulus(1, 1'b1, 5'd7, 32'hCAFE_0001);
      expGrant.push_back(1);
      expWr.push_back('{5'd7, 32'hCAFE_0001});
      #1;
      checkOutput("wb7_ready", 32'(req1_ready), 32'd1);
      checkOutput("wb7_hz1_pending", 32'(hz1), 32'd1);
      nextCycle();
      applyStimulus(1, 1'b0, 5'd0, 32'd0);
      #1;
      checkOutput("byp1_hit", 32'(byp1_hit), 32'd1);
      checkOutput("byp_hz1", 32'(hz1), 32'd0);
      checkOutput("byp_data", byp_data, 32'hCAFE_0001);
      checkOutput("byp2_hit_r0", 32'(byp2_hit), 32'd0);
      nextCycle();
      #1;
      checkOutput("after_hz1", 32'(hz1), 32'd0);
      checkOutput("after_byp1", 32'(byp1_hit), 32'd0);
      checkOutput("after_iss7_ready", 32'(iss_ready), 32'd1);

      // Register zero: never reserved, never written.
      nextCycle();
      iss_valid = 1'b1; iss_addr = 5'd0;
      #1;
      checkOutput("iss0_ready", 32'(iss_ready), 32'd1);
      nextCycle();
      iss_valid = 1'b0; raddr1 = 5'd0;
      applyStimulus(2, 1'b1, 5'd0, 32'h5555_5555);
      expGrant.push_back(2);
      #1;
      checkOutput("r0_hz1", 32'(hz1), 32'd0);
      checkOutput("wb0_ready", 32'(req2_ready), 32'd1);
      nextCycle();
      applyStimulus(2, 1'b0, 5'd0, 32'd0);
      #1;
      checkOutput("wb0_wen", 32'(wen), 32'd0);

      // Issue r3 in the same cycle that r9 commits.
      nextCycle();
      iss_valid = 1'b1; iss_addr = 5'd9;
      #1;
      checkOutput("iss9_ready", 32'(iss_ready), 32'd1);
      nextCycle();
      iss_valid = 1'b0;
      applyStimulus(0, 1'b1, 5'd9, 32'h0000_0099);
      expGrant.push_back(0);
      expWr.push_back('{5'd9, 32'h0000_0099});
      nextCycle();
      applyStimulus(0, 1'b0, 5'd0, 32'd0);
      iss_valid = 1'b1; iss_addr = 5'd3;
      #1;
      checkOutput("iss3_ready", 32'(iss_ready), 32'd1);
      nextCycle();
      iss_valid = 1'b0; iss_addr = 5'd9; raddr1 = 5'd3; raddr2 = 5'd9;
      #1;
      checkOutput("sim_hz1_r3", 32'(hz1), 32'd1);
      checkOutput("sim_hz2_r9", 32'(hz2), 32'd0);
      checkOutput("sim_iss9_ready", 32'(iss_ready), 32'd1);

      // Reset lands while a write is registered and r3 is reserved.
      nextCycle();
      applyStimulus(1, 1'b1, 5'd12, 32'h0000_ABCD);
      expGrant.push_back(1);
      nextCycle();
      applyStimulus(1, 1'b0, 5'd0, 32'd0);
      #1;
      checkOutput("pre_reset_wen", 32'(wen), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset_wen", 32'(wen), 32'd0);
      checkOutput("async_reset_wdata", wdata, 32'd0);
      iss_addr = 5'd3;
      #1;
      checkOutput("async_reset_hz1", 32'(hz1), 32'd0);
      checkOutput("async_reset_iss3", 32'(iss_ready), 32'd1);
      nextCycle();
      rst_n = 1'b1;
      nextCycle();
      #1;
      checkOutput("post_reset_wen", 32'(wen), 32'd0);
      nextCycle();
      checkOutput("grant_queue_empty", 32'(expGrant.size()), 32'd0);
      checkOutput("write_queue_empty", 32'(expWr.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
